lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store unit sitting directly downstream of the execute stage in the NPC core. It accepts one memory request at a time from the execute stage and converts it into a word-aligned SimpleBus transaction with byte lanes and write mask. It returns sign- or zero-extended load data, or a store acknowledge, to the register write-back path. It replaces the combinational DPI memory access with a multi-cycle valid/ready handshake, so data memory can have arbitrary latency.

## Interface
- `TIMEOUT`, default 255: watchdog limit in cycles spent waiting for a bus response. Used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: execute stage presents a request.
- `req_ready` out 1: LSU can accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as misaligned.
- `req_unsigned` in 1: zero-extend the load (lbu/lhu).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned access, bus error or timeout.
- `bus_req_valid` out 1: bus request.
- `bus_req_ready` in 1: bus accepts the request.
- `bus_req_wen` out 1: bus write.
- `bus_req_addr` out 32: word address, `{req_addr[31:2], 2'b0}`.
- `bus_req_wdata` out 32: lane-shifted store data.
- `bus_req_wmask` out 4: byte strobes; 0 on reads.
- `bus_rsp_valid` in 1: bus response. There is no ready; the LSU always accepts in WAIT.
- `bus_rsp_rdata` in 32: read word.
- `bus_rsp_err` in 1: bus error.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, capture `wen`, `addr`, `wdata`, `size`, `unsigned`.
  - Go to DONE with the error flag set if misaligned (half with `addr[0]=1`, word with `addr[1:0]≠0`, size 3). Otherwise go to REQ.
- REQ:
  - `bus_req_valid=1`; all `bus_req_*` outputs are stable until `bus_req_ready`.
  - On `bus_req_ready`, go to WAIT.
  - If `bus_rsp_valid` is also high in that same cycle, capture it and go straight to DONE (zero-latency slave).
- WAIT: on `bus_rsp_valid`, capture rdata and err, then go to DONE.
- DONE:
  - `rsp_valid=1` for exactly one cycle with the registered result, then return to IDLE.
  - `req_ready=0` in DONE, so back-to-back requests are spaced by at least one IDLE cycle.
- Store lanes (`off = addr[1:0]`):
  - Byte: wdata = `{4{wdata[7:0]}}`, mask = `4'b0001<<off`.
  - Half: wdata = `{2{wdata[15:0]}}`, mask = `4'b0011<<off`.
  - Word: wdata passes through, mask = `4'b1111`.
- Load extract: take `rdata >> (8*off)`, truncate to the access size, then sign-extend, or zero-extend if `unsigned`.
- `bus_rsp_valid` outside REQ/WAIT is ignored.
- When `rsp_err=1`, `rsp_rdata=0`.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `bus_req_valid=0`, `bus_req_wen=0`, `bus_req_addr=0`, `bus_req_wdata=0`, `bus_req_wmask=0`.
- Minimum latency, with the slave ready immediately and responding the next cycle:
  - accept in cycle 0;
  - `bus_req_valid` in cycle 1;
  - response in cycle 2;
  - `rsp_valid` in cycle 3.
- Misaligned request: `rsp_valid`+`rsp_err` in cycle 1; no bus activity.
- Reset asserted in any state: state returns to IDLE on the next edge and `bus_req_valid` drops. A response still in flight from the slave is then ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit+ counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches `TIMEOUT` without a handshake or response, go to DONE with `rsp_err=1`.
  - A response arriving in the same cycle as expiry wins.
- `LSU_TIMEOUT_EN` undefined: no counter is present, and the LSU waits indefinitely.

## Structure
- Package `lsu_pkg`:
  - size encoding localparams (`SZ_B`, `SZ_H`, `SZ_W`);
  - state enum `lsu_state_t`;
  - `TIMEOUT` default.
- Sub-module `lsu_align` (combinational): store lane shift and mask generation, load extract and extension, misalignment detect.
- The FSM, capture registers and watchdog live in `lsu_bus_ctrl`.

## Test plan
- `lbu`, addr 0x80000003, bus rdata 0x80AB_CDEF, `unsigned=1` -> `rsp_rdata=0x80`, `rsp_err=0`; with `unsigned=0` -> `0xFFFF_FF80`.
- `sb`, addr 0x80000002, wdata 0x1234_5678 -> `bus_req_addr=0x80000000`, `wmask=4'b0100`, wdata `0x7878_7878`.
- `sw`, addr 0x80000006 -> `rsp_valid`+`rsp_err=1` in cycle 1, `bus_req_valid` never asserted.
- Slave holds `bus_req_ready=0` for 5 cycles, then responds 3 cycles later with `0xDEADBEEF`; `lw` -> bus outputs stable throughout, `rsp_rdata=0xDEADBEEF` one cycle after `bus_rsp_valid`.
- Reset asserted while in WAIT, stale response arrives in IDLE -> no `rsp_valid`, `req_ready=1`.
- With `LSU_TIMEOUT_EN` and `TIMEOUT=10`, a slave that never responds -> `rsp_err=1` after 10 cycles in REQ/WAIT.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wmask,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  // Lane steering and extension selected by access size; size 3 falls to the error default.
  always_comb begin
    shifted    = load_word >> {off, 3'b000};
    sign_b     = ~is_unsigned & shifted[7];
    sign_h     = ~is_unsigned & shifted[15];
    lane_wdata = store_data;
    lane_wmask = 4'b0000;
    load_data  = shifted;
    misaligned = 1'b1;
    case (size)
      SZ_B: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wmask = 4'b0001 << off;
        load_data  = {{24{sign_b}}, shifted[7:0]};
        misaligned = 1'b0;
      end
      SZ_H: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wmask = 4'b0011 << off;
        load_data  = {{16{sign_h}}, shifted[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        lane_wdata = store_data;
        lane_wmask = 4'b1111;
        load_data  = shifted;
        misaligned = (off != 2'b00);
      end
      default: begin
        lane_wdata = store_data;
        lane_wmask = 4'b0000;
        load_data  = 32'h0000_0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: one request at a time onto a word-aligned valid/ready bus.
// Define LSU_TIMEOUT_EN to add a response watchdog limited by TIMEOUT.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wmask,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  lsu_state_t  state;
  lsu_state_t  state_next;

  logic        wen_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic        uns_r;
  logic        bus_wen_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [3:0]  bus_wmask_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        accept_s;
  logic        capture_s;
  logic        expire_s;
  logic        timeout_s;

  logic [1:0]  size_s;
  logic [1:0]  off_s;
  logic        uns_s;
  logic [31:0] lane_wdata_s;
  logic [3:0]  lane_wmask_s;
  logic [31:0] load_data_s;
  logic        misaligned_s;

  // The aligner sees the live request while idle and the captured request afterwards.
  assign size_s = (state == IDLE) ? req_size      : size_r;
  assign off_s  = (state == IDLE) ? req_addr[1:0] : off_r;
  assign uns_s  = (state == IDLE) ? req_unsigned  : uns_r;

  lsu_align u_align (
    .size        (size_s),
    .off         (off_s),
    .is_unsigned (uns_s),
    .store_data  (req_wdata),
    .load_word   (bus_rsp_rdata),
    .lane_wdata  (lane_wdata_s),
    .lane_wmask  (lane_wmask_s),
    .load_data   (load_data_s),
    .misaligned  (misaligned_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog: restarts with each accepted request, counts every cycle spent in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_r <= '0;
    end else if (accept_s) begin
      wd_cnt_r <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

  assign timeout_s = (wd_cnt_r >= CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a response always takes priority over watchdog expiry.
  always_comb begin
    state_next = state;
    accept_s   = 1'b0;
    capture_s  = 1'b0;
    expire_s   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_s   = 1'b1;
          state_next = misaligned_s ? DONE : REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          if (bus_rsp_valid) begin
            capture_s  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end else if (timeout_s) begin
          expire_s   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          capture_s  = 1'b1;
          state_next = DONE;
        end else if (timeout_s) begin
          expire_s   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, bus request registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_r       <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      uns_r       <= 1'b0;
      bus_wen_r   <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_wdata_r <= 32'h0000_0000;
      bus_wmask_r <= 4'b0000;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else if (accept_s) begin
      wen_r       <= req_wen;
      size_r      <= req_size;
      off_r       <= req_addr[1:0];
      uns_r       <= req_unsigned;
      bus_wen_r   <= req_wen;
      bus_addr_r  <= {req_addr[31:2], 2'b00};
      bus_wdata_r <= lane_wdata_s;
      bus_wmask_r <= req_wen ? lane_wmask_s : 4'b0000;
      rdata_r     <= 32'h0000_0000;
      err_r       <= misaligned_s;
    end else if (capture_s) begin
      rdata_r <= (bus_rsp_err || wen_r) ? 32'h0000_0000 : load_data_s;
      err_r   <= bus_rsp_err;
    end else if (expire_s) begin
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b1;
    end
  end

  assign req_ready     = (state == IDLE);
  assign rsp_valid     = (state == DONE);
  assign rsp_rdata     = rdata_r;
  assign rsp_err       = err_r;
  assign bus_req_valid = (state == REQ);
  assign bus_req_wen   = bus_wen_r;
  assign bus_req_addr  = bus_addr_r;
  assign bus_req_wdata = bus_wdata_r;
  assign bus_req_wmask = bus_wmask_r;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: vector table, corner sequences, randomized model check.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_wen;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wmask;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = 32'h0;
  logic        bus_rsp_err = 1'b0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_wen   (bus_req_wen),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wmask (bus_req_wmask),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] brdata;
    logic        berr;
    logic        x_bus;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_wmask;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] o_rdata;
  logic        o_err;
  int          o_lat;
  int          o_rsp_cyc;
  logic        o_bus;
  logic        o_stable;
  logic        o_done;
  logic        o_pulse_ok;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wmask;
  logic        o_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: derives bus lanes and result from address arithmetic alone.
  function automatic vec_t model(input vec_t v);
    vec_t            r;
    int              nbytes;
    int              off;
    int              m;
    longint unsigned lim;
    longint unsigned val;
    r      = v;
    off    = int'(v.addr % 32'd4);
    nbytes = (v.size == 2'd3) ? 4 : (1 << v.size);
    r.x_bus  = (v.size != 2'd3) && ((v.addr % nbytes) == 0);
    r.x_addr = v.addr - off;
    if (v.size == 2'd0)      r.x_wdata = v.wdata[7:0] * 32'h0101_0101;
    else if (v.size == 2'd1) r.x_wdata = v.wdata[15:0] * 32'h0001_0001;
    else                     r.x_wdata = v.wdata;
    m = ((1 << nbytes) - 1) << off;
    r.x_wmask = v.wen ? m[3:0] : 4'b0000;
    lim = 64'd1 << (8 * nbytes);
    val = (64'(v.brdata) >> (8 * off)) % lim;
    if (!v.uns && (val >= lim / 2)) val = val + (64'h1_0000_0000 - lim);
    r.x_err   = !r.x_bus || v.berr;
    r.x_rdata = (r.x_err || v.wen) ? 32'h0 : val[31:0];
    return r;
  endfunction

  // Issue one request and act as the slave; results land in the o_* variables.
  task automatic run_txn(input vec_t v, input int rdly, input int rspdly, input bit no_rsp);
    int n_valid;
    bit hs;
    int wcnt;
    bit sent;
    n_valid = 0; hs = 0; wcnt = 0; sent = 0;
    o_done = 1'b0; o_bus = 1'b0; o_stable = 1'b1; o_rsp_cyc = -1; o_lat = -1;
    o_rdata = 32'h0; o_err = 1'b0; o_pulse_ok = 1'b0;
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    for (int c = 1; c <= 300 && !o_done; c++) begin
      @(negedge clk);
      req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
      if (rsp_valid) begin
        o_done = 1'b1; o_lat = c; o_rdata = rsp_rdata; o_err = rsp_err;
      end else if (bus_req_valid) begin
        if (!o_bus) begin
          o_bus = 1'b1; o_addr = bus_req_addr; o_wdata = bus_req_wdata;
          o_wmask = bus_req_wmask; o_wen = bus_req_wen;
        end else if ({bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen} !==
                     {o_addr, o_wdata, o_wmask, o_wen}) begin
          o_stable = 1'b0;
        end
        if (n_valid >= rdly) begin
          bus_req_ready = 1'b1; hs = 1;
          if (rspdly == 0 && !no_rsp) begin
            bus_rsp_valid = 1'b1; bus_rsp_rdata = v.brdata; bus_rsp_err = v.berr;
            sent = 1; o_rsp_cyc = c;
          end
        end
        n_valid++;
      end else if (hs && !sent && !no_rsp) begin
        wcnt++;
        if (wcnt >= rspdly) begin
          bus_rsp_valid = 1'b1; bus_rsp_rdata = v.brdata; bus_rsp_err = v.berr;
          sent = 1; o_rsp_cyc = c;
        end
      end
    end
    if (o_done) begin
      @(negedge clk);
      o_pulse_ok = !rsp_valid && req_ready;
    end else begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no rsp_valid expected one within 300 cycles");
    end
  endtask

  task automatic check_result(input string tag, input vec_t x, input int x_lat);
    chk($sformatf("%s.err", tag), 32'(o_err), 32'(x.x_err));
    chk($sformatf("%s.rdata", tag), o_rdata, x.x_rdata);
    chk($sformatf("%s.bus_seen", tag), 32'(o_bus), 32'(x.x_bus));
    chk($sformatf("%s.latency", tag), o_lat, x_lat);
    chk($sformatf("%s.one_pulse", tag), 32'(o_pulse_ok), 32'd1);
    if (x.x_bus) begin
      chk($sformatf("%s.addr", tag), o_addr, x.x_addr);
      chk($sformatf("%s.wmask", tag), 32'(o_wmask), 32'(x.x_wmask));
      chk($sformatf("%s.wen", tag), 32'(o_wen), 32'(x.wen));
      chk($sformatf("%s.stable", tag), 32'(o_stable), 32'd1);
      if (x.wen) chk($sformatf("%s.wdata", tag), o_wdata, x.x_wdata);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    vec_t v;
    vec_t x;
    int   rdly;
    int   rspdly;

    // wen addr wdata size uns brdata berr | bus addr wdata wmask rdata err
    tbl[0]  = '{1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b1, 32'h80AB_CDEF, 1'b0,
                1'b1, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080, 1'b0};
    tbl[1]  = '{1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b0, 32'h80AB_CDEF, 1'b0,
                1'b1, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{1'b1, 32'h8000_0002, 32'h1234_5678, SZ_B, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h8000_0000, 32'h7878_7878, 4'b0100, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h8000_0006, 32'h1111_2222, SZ_W, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h8000_0004, 32'h0, 4'b0000, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 32'h8000_0002, 32'h0, SZ_H, 1'b0, 32'h80AB_CDEF, 1'b0,
                1'b1, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_80AB, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0, SZ_H, 1'b1, 32'h1234_5678, 1'b0,
                1'b1, 32'h0000_0010, 32'h0, 4'b0000, 32'h0000_5678, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0004, 32'h0, SZ_W, 1'b0, 32'hDEAD_BEEF, 1'b0,
                1'b1, 32'h0000_0004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0102, 32'hAABB_CCDD, SZ_H, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h0000_0100, 32'hCCDD_CCDD, 4'b1100, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0, 2'd3, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0000_0020, 32'h0, SZ_W, 1'b0, 32'h1234_5678, 1'b1,
                1'b1, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0001, 32'h0, SZ_H, 1'b1, 32'h0, 1'b0,
                1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 32'h0000_0001, 32'h0, SZ_B, 1'b0, 32'h0000_7F00, 1'b0,
                1'b1, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_007F, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0003, 32'h0000_00AB, SZ_B, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h0000_0000, 32'hABAB_ABAB, 4'b1000, 32'h0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.bus_valid", 32'(bus_req_valid), 32'd0);
    chk("reset.bus_wen", 32'(bus_req_wen), 32'd0);
    chk("reset.bus_addr", bus_req_addr, 32'h0);
    chk("reset.bus_wdata", bus_req_wdata, 32'h0);
    chk("reset.bus_wmask", 32'(bus_req_wmask), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset.req_ready", 32'(req_ready), 32'd1);

    // Table vectors with the minimum-latency slave.
    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i], 0, 1, 1'b0);
      check_result($sformatf("vec%0d", i), tbl[i], tbl[i].x_bus ? 3 : 1);
    end

    // Slave stalls 5 cycles, then answers 3 cycles after the handshake.
    v = '{1'b0, 32'h8000_0010, 32'h0, SZ_W, 1'b0, 32'hDEAD_BEEF, 1'b0,
          1'b1, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    run_txn(v, 5, 3, 1'b0);
    check_result("stall", v, 10);
    chk("stall.rsp_after_bus", o_lat, o_rsp_cyc + 1);

    // Reset while waiting, then a stale response reaches an idle LSU.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0100; req_size = SZ_W;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw.bus_valid", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rstw.in_wait", 32'(bus_req_valid | rsp_valid | req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rstw.bus_dropped", 32'(bus_req_valid), 32'd0);
    chk("rstw.ready", 32'(req_ready), 32'd1);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstw.no_rsp%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("rstw.ready%0d", k), 32'(req_ready), 32'd1);
      @(negedge clk);
    end

`ifdef LSU_TIMEOUT_EN
    // Slave accepts but never answers: 10 cycles in REQ/WAIT, then an error.
    v = '{1'b0, 32'h0000_0040, 32'h0, SZ_W, 1'b0, 32'h0, 1'b0,
          1'b1, 32'h0000_0040, 32'h0, 4'b0000, 32'h0, 1'b1};
    run_txn(v, 0, 0, 1'b1);
    check_result("timeout", v, 11);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.wen   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.brdata = $urandom;
      v.berr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0 && v.size != 2'd3)
        v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
      rdly   = $urandom_range(0, 3);
      rspdly = $urandom_range(0, 3);
      x = model(v);
      run_txn(v, rdly, rspdly, 1'b0);
      check_result($sformatf("rand%0d", i), x, x.x_bus ? (2 + rdly + rspdly) : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
